// File: rtl/kmeans_host_link_pkg.sv
// Shared definitions for the k-means host link: core register map,
// link FSM states and the run-timeout counter width.
package kmeans_host_link_pkg;

  // Register numbers used by the core's write-back port
  typedef enum logic [7:0] {
    INTERNAL_STATUS = 8'd0,
    GO              = 8'd1,
    CENT_1          = 8'd2,
    CENT_2          = 8'd3,
    CENT_3          = 8'd4,
    CENT_4          = 8'd5,
    CENT_5          = 8'd6,
    CENT_6          = 8'd7,
    CENT_7          = 8'd8,
    CENT_8          = 8'd9
  } reg_num_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_e;

  localparam int unsigned TIMEOUT_W = 20;
  localparam int unsigned N_CENT    = 8;

  // True when a write-back register number addresses a centroid slot
  function automatic logic is_cent_reg(input logic [7:0] num);
    return (num >= CENT_1) && (num <= CENT_8);
  endfunction

endpackage

// File: rtl/kmeans_cent_bank.sv
// Eight-entry centroid register bank: one synchronous write port with a
// bulk clear, plus a combinational read mux.
module kmeans_cent_bank
  import kmeans_host_link_pkg::*;
#(
  parameter int unsigned DATA_W = 91
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              we,
  input  logic [2:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [2:0]        rsel,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] cent [N_CENT];

  // Clear on reset or a new load; otherwise capture core write-backs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_CENT; i++) cent[i] <= '0;
    end else if (clr) begin
      for (int unsigned i = 0; i < N_CENT; i++) cent[i] <= '0;
    end else if (we) begin
      cent[waddr] <= wdata;
    end
  end

  assign rdata = cent[rsel];

endmodule

// File: rtl/kmeans_host_link.sv
// Host link for the k-means core: streams host points into core RAM,
// starts the core, collects centroid write-backs and reports completion.
// Optional run timeout enabled by defining KMEANS_HOST_LINK_TIMEOUT_EN.
module kmeans_host_link
  import kmeans_host_link_pkg::*;
#(
  parameter int unsigned DATA_W = 91,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned THR_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [THR_W-1:0]  thr_in,
  input  logic              pt_valid,
  output logic              pt_ready,
  input  logic [DATA_W-1:0] pt_data,
  input  logic              pt_last,
  output logic [ADDR_W-1:0] adress2core,
  output logic [DATA_W-1:0] data2core,
  output logic              W_R_RAM_N,
  output logic              CHIP_SEL_RAM_N,
  output logic              go_core,
  output logic [ADDR_W-1:0] first_ram_address,
  output logic [ADDR_W-1:0] last_ram_address,
  output logic [THR_W-1:0]  threshold_value,
  input  logic [7:0]        reg_num,
  input  logic              reg_w_r,
  input  logic [DATA_W-1:0] reg_write_data,
  input  logic              interupt,
  input  logic [2:0]        res_sel,
  output logic [DATA_W-1:0] res_data,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic              timeout
);

  state_e            state;
  logic [ADDR_W-1:0] ptr;
  logic              last_pend;
  logic              int_q;
  logic              int_rise;
  logic              accept;
  logic              load_go;
  logic              tmo_hit;
  logic              cent_we;

  assign accept   = pt_valid & pt_ready;
  assign load_go  = start & ((state == S_IDLE) | (state == S_DONE));
  assign int_rise = (state == S_RUN) & interupt & ~int_q;
  assign cent_we  = (state == S_RUN) & reg_w_r & is_cent_reg(reg_num);

`ifdef KMEANS_HOST_LINK_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic                 timeout_q;

  assign tmo_hit = (state == S_RUN) & (tmo_cnt == '1) & ~int_rise;
  assign timeout = timeout_q;

  // Run-length counter: held at zero outside RUN so it starts fresh on entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt   <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == S_RUN) tmo_cnt <= tmo_cnt + 1'b1;
      else                tmo_cnt <= '0;
      if (load_go)      timeout_q <= 1'b0;
      else if (tmo_hit) timeout_q <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

  // Interrupt history for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) int_q <= 1'b0;
    else     int_q <= interupt;
  end

  // Link FSM with registered RAM-write, handshake and status outputs.
  // The last beat parks in LOAD for one cycle (last_pend) so RUN begins
  // only after its write pulse has been presented to the core.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= S_IDLE;
      ptr               <= '0;
      last_pend         <= 1'b0;
      first_ram_address <= '0;
      last_ram_address  <= '0;
      threshold_value   <= '0;
      adress2core       <= '0;
      data2core         <= '0;
      W_R_RAM_N         <= 1'b1;
      CHIP_SEL_RAM_N    <= 1'b1;
      go_core           <= 1'b0;
      pt_ready          <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      ovf               <= 1'b0;
    end else begin
      W_R_RAM_N      <= 1'b1;
      CHIP_SEL_RAM_N <= 1'b1;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state             <= S_LOAD;
            ptr               <= base_addr;
            first_ram_address <= base_addr;
            threshold_value   <= thr_in;
            last_pend         <= 1'b0;
            done              <= 1'b0;
            ovf               <= 1'b0;
            pt_ready          <= 1'b1;
            busy              <= 1'b1;
          end
        end
        S_LOAD: begin
          if (last_pend) begin
            state     <= S_RUN;
            last_pend <= 1'b0;
            go_core   <= 1'b1;
          end else if (accept) begin
            W_R_RAM_N      <= 1'b0;
            CHIP_SEL_RAM_N <= 1'b0;
            adress2core    <= ptr;
            data2core      <= pt_data;
            if (ptr != '1) ptr <= ptr + 1'b1;
            if (pt_last || (ptr == '1)) begin
              last_ram_address <= ptr;
              last_pend        <= 1'b1;
              pt_ready         <= 1'b0;
              if (!pt_last) ovf <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (int_rise || tmo_hit) begin
            state   <= S_DONE;
            go_core <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  kmeans_cent_bank #(
    .DATA_W (DATA_W)
  ) u_cent_bank (
    .clk   (clk),
    .rst   (rst),
    .clr   (load_go),
    .we    (cent_we),
    .waddr (reg_num[2:0] - 3'd2),
    .wdata (reg_write_data),
    .rsel  (res_sel),
    .rdata (res_data)
  );

endmodule

// File: tb/tb_kmeans_host_link.sv
// Self-checking bench for kmeans_host_link: RAM writes are checked against
// a scoreboard queue, centroids against a local model.
module tb_kmeans_host_link;

  localparam int unsigned DW = 91;
  localparam int unsigned AW = 9;
  localparam int unsigned TW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [TW-1:0] thr_in;
  logic          pt_valid;
  logic          pt_ready;
  logic [DW-1:0] pt_data;
  logic          pt_last;
  logic [AW-1:0] adress2core;
  logic [DW-1:0] data2core;
  logic          W_R_RAM_N;
  logic          CHIP_SEL_RAM_N;
  logic          go_core;
  logic [AW-1:0] first_ram_address;
  logic [AW-1:0] last_ram_address;
  logic [TW-1:0] threshold_value;
  logic [7:0]    reg_num;
  logic          reg_w_r;
  logic [DW-1:0] reg_write_data;
  logic          interupt;
  logic [2:0]    res_sel;
  logic [DW-1:0] res_data;
  logic          busy;
  logic          done;
  logic          ovf;
  logic          timeout;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  logic [DW-1:0] model [8];
  int            vectors     = 0;
  int            miscompares = 0;

  always #5 clk = ~clk;

  kmeans_host_link #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .THR_W  (TW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .base_addr         (base_addr),
    .thr_in            (thr_in),
    .pt_valid          (pt_valid),
    .pt_ready          (pt_ready),
    .pt_data           (pt_data),
    .pt_last           (pt_last),
    .adress2core       (adress2core),
    .data2core         (data2core),
    .W_R_RAM_N         (W_R_RAM_N),
    .CHIP_SEL_RAM_N    (CHIP_SEL_RAM_N),
    .go_core           (go_core),
    .first_ram_address (first_ram_address),
    .last_ram_address  (last_ram_address),
    .threshold_value   (threshold_value),
    .reg_num           (reg_num),
    .reg_w_r           (reg_w_r),
    .reg_write_data    (reg_write_data),
    .interupt          (interupt),
    .res_sel           (res_sel),
    .res_data          (res_data),
    .busy              (busy),
    .done              (done),
    .ovf               (ovf),
    .timeout           (timeout)
  );

  function automatic logic [DW-1:0] rnd();
    return DW'({$urandom, $urandom, $urandom});
  endfunction

  // Advance one clock; any RAM write pulse seen is popped from the scoreboard
  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    if (CHIP_SEL_RAM_N !== 1'b1 || W_R_RAM_N !== 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL ram_write_unexpected: got addr %0d cs_n %b wr_n %b, required no write",
                 adress2core, CHIP_SEL_RAM_N, W_R_RAM_N);
      end else begin
        e = exp_q.pop_front();
        if ({CHIP_SEL_RAM_N, W_R_RAM_N, adress2core, data2core} !== {2'b00, e.addr, e.data}) begin
          miscompares++;
          $display("FAIL ram_write: got cs_n %b wr_n %b addr %0d data %h, required 0 0 %0d %h",
                   CHIP_SEL_RAM_N, W_R_RAM_N, adress2core, data2core, e.addr, e.data);
        end
      end
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) model[i] = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; base_addr = '0; thr_in = '0;
    pt_valid = 1'b0; pt_data = '0; pt_last = 1'b0;
    reg_num = '0; reg_w_r = 1'b0; reg_write_data = '0; interupt = 1'b0; res_sel = '0;
    exp_q.delete();
    clear_model();
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({first_ram_address, last_ram_address, threshold_value, adress2core, data2core,
         W_R_RAM_N, CHIP_SEL_RAM_N, go_core, pt_ready, busy, done, ovf, timeout} !==
        {{AW{1'b0}}, {AW{1'b0}}, {TW{1'b0}}, {AW{1'b0}}, {DW{1'b0}}, 8'b1100_0000}) begin
      miscompares++;
      $display("FAIL reset_outputs: got first %0d last %0d thr %h addr %0d wr_n %b cs_n %b go %b rdy %b busy %b done %b ovf %b tmo %b, required zeros with wr_n/cs_n=1",
               first_ram_address, last_ram_address, threshold_value, adress2core, W_R_RAM_N,
               CHIP_SEL_RAM_N, go_core, pt_ready, busy, done, ovf, timeout);
    end
    for (int s = 0; s < 8; s++) begin
      res_sel = 3'(s); #1;
      vectors++;
      if (res_data !== '0) begin
        miscompares++;
        $display("FAIL reset_cent%0d: got %h, required 0", s, res_data);
      end
    end
    // Beats offered while idle must not be taken
    pt_valid = 1'b1; pt_data = rnd();
    tick(); tick();
    vectors++;
    if (pt_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_ready: got %b, required 0", pt_ready);
    end
    pt_valid = 1'b0;
  endtask

  task automatic test_load_basic();
    logic [DW-1:0] d;
    start = 1'b1; base_addr = 9'd5; thr_in = 16'h1234;
    tick();
    start = 1'b0; clear_model();
    vectors++;
    if ({first_ram_address, threshold_value, pt_ready, busy} !== {9'd5, 16'h1234, 2'b11}) begin
      miscompares++;
      $display("FAIL load_entry: got first %0d thr %h rdy %b busy %b, required 5 1234 1 1",
               first_ram_address, threshold_value, pt_ready, busy);
    end
    for (int b = 0; b < 3; b++) begin
      d = rnd();
      pt_valid = 1'b1; pt_data = d; pt_last = (b == 2);
      // A start during LOAD must not restart the load
      start = (b == 1); base_addr = 9'd100;
      exp_q.push_back('{addr: 9'(5 + b), data: d});
      tick();
    end
    pt_valid = 1'b0; pt_last = 1'b0; start = 1'b0;
    vectors++;
    if ({go_core, pt_ready, last_ram_address, first_ram_address} !== {2'b00, 9'd7, 9'd5}) begin
      miscompares++;
      $display("FAIL load_last: got go %b rdy %b last %0d first %0d, required 0 0 7 5",
               go_core, pt_ready, last_ram_address, first_ram_address);
    end
    tick();
    vectors++;
    if ({go_core, busy, done} !== 3'b110) begin
      miscompares++;
      $display("FAIL run_entry: got go %b busy %b done %b, required 1 1 0", go_core, busy, done);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL load_writes_missing: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] d;
    do_reset();
    start = 1'b1; base_addr = 9'd510; thr_in = 16'h00ff;
    tick();
    start = 1'b0; clear_model();
    for (int b = 0; b < 4; b++) begin
      d = rnd();
      pt_valid = 1'b1; pt_data = d; pt_last = 1'b0;
      if (b < 2) exp_q.push_back('{addr: 9'(510 + b), data: d});
      tick();
      if (b == 1) begin
        vectors++;
        if ({pt_ready, ovf, last_ram_address} !== {2'b01, 9'd511}) begin
          miscompares++;
          $display("FAIL ovf_last: got rdy %b ovf %b last %0d, required 0 1 511",
                   pt_ready, ovf, last_ram_address);
        end
      end
      if (b == 2) begin
        vectors++;
        if (go_core !== 1'b1) begin
          miscompares++;
          $display("FAIL ovf_run: got go %b, required 1", go_core);
        end
      end
    end
    pt_valid = 1'b0;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL ovf_writes_missing: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_writeback();
    logic [7:0]    nums  [5];
    logic [DW-1:0] datas [5];
    nums[0] = 8'd2; datas[0] = DW'(32'hA);
    nums[1] = 8'd9; datas[1] = DW'(32'hB);
    nums[2] = 8'd1; datas[2] = DW'(32'hC);
    nums[3] = 8'd0; datas[3] = rnd();
    nums[4] = 8'd10; datas[4] = rnd();
    for (int i = 0; i < 5; i++) begin
      reg_w_r = 1'b1; reg_num = nums[i]; reg_write_data = datas[i];
      if (nums[i] >= 8'd2 && nums[i] <= 8'd9) model[nums[i] - 8'd2] = datas[i];
      tick();
    end
    reg_w_r = 1'b0;
    for (int s = 0; s < 8; s++) begin
      res_sel = 3'(s); #1;
      vectors++;
      if (res_data !== model[s]) begin
        miscompares++;
        $display("FAIL wb_cent%0d: got %h, required %h", s, res_data, model[s]);
      end
    end
  endtask

  task automatic test_interrupt();
    logic [DW-1:0] d;
    d = rnd();
    reg_w_r = 1'b1; reg_num = 8'd4; reg_write_data = d; interupt = 1'b1;
    model[2] = d;
    tick();
    vectors++;
    if ({done, go_core, busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL irq_done: got done %b go %b busy %b, required 1 0 0", done, go_core, busy);
    end
    // Write-backs and interrupt edges in DONE are ignored
    reg_num = 8'd3; reg_write_data = rnd(); interupt = 1'b0;
    tick();
    interupt = 1'b1; reg_w_r = 1'b0;
    tick(); tick();
    interupt = 1'b0;
    vectors++;
    if ({done, go_core, busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL done_hold: got done %b go %b busy %b, required 1 0 0", done, go_core, busy);
    end
    for (int s = 0; s < 8; s++) begin
      res_sel = 3'(s); #1;
      vectors++;
      if (res_data !== model[s]) begin
        miscompares++;
        $display("FAIL irq_cent%0d: got %h, required %h", s, res_data, model[s]);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    logic [DW-1:0] d;
    start = 1'b1; base_addr = 9'd20; thr_in = 16'hbeef;
    tick();
    start = 1'b0; clear_model();
    for (int b = 0; b < 2; b++) begin
      d = rnd();
      pt_valid = 1'b1; pt_data = d; pt_last = 1'b0;
      exp_q.push_back('{addr: 9'(20 + b), data: d});
      tick();
    end
    pt_data = rnd();
    #3 rst = 1'b1;
    #1;
    vectors++;
    if ({first_ram_address, last_ram_address, threshold_value, adress2core, data2core,
         W_R_RAM_N, CHIP_SEL_RAM_N, go_core, pt_ready, busy, done, ovf, timeout} !==
        {{AW{1'b0}}, {AW{1'b0}}, {TW{1'b0}}, {AW{1'b0}}, {DW{1'b0}}, 8'b1100_0000}) begin
      miscompares++;
      $display("FAIL async_reset: got first %0d last %0d thr %h addr %0d wr_n %b cs_n %b go %b rdy %b busy %b done %b ovf %b, required zeros with wr_n/cs_n=1",
               first_ram_address, last_ram_address, threshold_value, adress2core, W_R_RAM_N,
               CHIP_SEL_RAM_N, go_core, pt_ready, busy, done, ovf);
    end
    res_sel = 3'd2; #1;
    vectors++;
    if (res_data !== '0) begin
      miscompares++;
      $display("FAIL async_reset_cent: got %h, required 0", res_data);
    end
    tick();
    rst = 1'b0;
    tick(); tick();
    pt_valid = 1'b0;
    start = 1'b1; base_addr = 9'd40; thr_in = 16'h0042;
    tick();
    start = 1'b0;
    vectors++;
    if ({first_ram_address, threshold_value, pt_ready} !== {9'd40, 16'h0042, 1'b1}) begin
      miscompares++;
      $display("FAIL reload_entry: got first %0d thr %h rdy %b, required 40 0042 1",
               first_ram_address, threshold_value, pt_ready);
    end
    d = rnd();
    pt_valid = 1'b1; pt_data = d; pt_last = 1'b1;
    exp_q.push_back('{addr: 9'd40, data: d});
    tick();
    pt_valid = 1'b0; pt_last = 1'b0;
    tick();
    vectors++;
    if ({go_core, last_ram_address, ovf} !== {1'b1, 9'd40, 1'b0}) begin
      miscompares++;
      $display("FAIL reload_run: got go %b last %0d ovf %b, required 1 40 0",
               go_core, last_ram_address, ovf);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL reload_writes_missing: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_timeout();
    // Currently in RUN from the reload; a start here must be ignored
    start = 1'b1; base_addr = 9'd300;
    tick();
    start = 1'b0;
`ifdef KMEANS_HOST_LINK_TIMEOUT_EN
    for (int c = 0; c < (1 << 20) + 16; c++) begin
      if (done === 1'b1) break;
      tick();
    end
    vectors++;
    if ({done, timeout, go_core} !== 3'b110) begin
      miscompares++;
      $display("FAIL timeout_fire: got done %b tmo %b go %b, required 1 1 0", done, timeout, go_core);
    end
`else
    for (int c = 0; c < 300; c++) tick();
    vectors++;
    if ({go_core, done, timeout, first_ram_address} !== {3'b100, 9'd40}) begin
      miscompares++;
      $display("FAIL no_timeout: got go %b done %b tmo %b first %0d, required 1 0 0 40",
               go_core, done, timeout, first_ram_address);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_overflow();
    test_writeback();
    test_interrupt();
    test_reset_mid_load();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
